mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 44 ++++
 rtl/mem_access_lane_align.sv | 32 +++
 rtl/mem_access.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the mem_access load/store block:
// access size encodings, FSM state encoding and byte-lane masks.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  // Byte-enable pattern of an access of the given size at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return MASK_B;
      SZ_H:    return MASK_H;
      SZ_W:    return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_low_bits(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// mem_lane_align: purely combinational byte-lane steering.
// Store side: byte enables and left-shifted write data for a byte offset.
// Load side: right-shift read data to lane 0, truncate to size, extend.
module mem_lane_align (
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [2:0]  offset,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext
);
  import mem_access_pkg::*;

  logic [63:0] rdata_sh;

  // Lane shifting in both directions plus load truncation/extension.
  always_comb begin
    be        = size_mask(size) << offset;
    wdata_sh  = wdata << {offset, 3'b000};
    rdata_sh  = rdata >> {offset, 3'b000};
    rdata_ext = rdata_sh;
    case (size)
      SZ_B:    rdata_ext = sgn ? {{56{rdata_sh[7]}},  rdata_sh[7:0]}  : {56'd0, rdata_sh[7:0]};
      SZ_H:    rdata_ext = sgn ? {{48{rdata_sh[15]}}, rdata_sh[15:0]} : {48'd0, rdata_sh[15:0]};
      SZ_W:    rdata_ext = sgn ? {{32{rdata_sh[31]}}, rdata_sh[31:0]} : {32'd0, rdata_sh[31:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: single-outstanding load/store unit between a core request
// port and a 64-bit synchronous SRAM (read data one cycle after mem_en).
// All outputs are registered. Optional feature macro:
//   MEM_ACCESS_ALIGN_CHECK_EN - misaligned accesses return resp_err=1
//   without touching memory; when undefined, low address bits are cleared
//   to natural alignment and resp_err is always 0.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic [7:0]  mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);
  import mem_access_pkg::*;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [2:0]  off_q, off_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_en_q, mem_en_d;
  logic [7:0]  mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;

  logic [63:0] req_addr_al;
  logic        req_misaligned;
  logic [1:0]  lane_size;
  logic        lane_sgn;
  logic [2:0]  lane_off;
  logic [7:0]  lane_be;
  logic [63:0] lane_wdata;
  logic [63:0] lane_rdata;

  // Aligned view of the incoming address; only differs when misaligned.
  assign req_addr_al = {req_addr[63:3], req_addr[2:0] & ~size_low_bits(req_size)};

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign req_misaligned = |(req_addr[2:0] & size_low_bits(req_size));
`else
  assign req_misaligned = 1'b0;
`endif

  // The lane unit serves the incoming store in IDLE and the latched load in WAIT.
  always_comb begin
    lane_size = size_q;
    lane_sgn  = sgn_q;
    lane_off  = off_q;
    if (state_q == ST_IDLE) begin
      lane_size = req_size;
      lane_sgn  = req_signed;
      lane_off  = req_addr_al[2:0];
    end
  end

  mem_lane_align u_lane (
    .size      (lane_size),
    .sgn       (lane_sgn),
    .offset    (lane_off),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (lane_be),
    .wdata_sh  (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  // Next-state and registered-output logic; memory strobes default to idle.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    off_d        = off_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 8'h00;
    mem_wdata_d  = 64'd0;
    mem_addr_d   = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          size_d      = req_size;
          sgn_d       = req_signed;
          off_d       = req_addr_al[2:0];
          mem_addr_d  = {req_addr_al[63:3], 3'b000};
          req_ready_d = 1'b0;
          if (req_misaligned) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 64'd0;
          end else begin
            state_d     = ST_ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = req_we ? lane_be : 8'h00;
            mem_wdata_d = req_we ? lane_wdata : 64'd0;
          end
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = 64'd0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = lane_rdata;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 64'd0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      sgn_q        <= 1'b0;
      off_q        <= 3'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 8'h00;
      mem_addr_q   <= 64'd0;
      mem_wdata_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      off_q        <= off_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
